// File: rtl/y86_mem_pkg.sv
// y86_mem_pkg: shared definitions for the Y86 unified memory port.
//   - arbiter FSM state encoding and last-grant encoding
//   - default backing-memory size, instruction length, data access width
//   - range-check helper used for both fetch and data requests
package y86_mem_pkg;

    localparam int MEM_BYTES_DEFAULT = 4096;
    localparam int INSTR_BYTES       = 10;
    localparam int DATA_BYTES        = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        F_BEAT0 = 2'd1,
        F_BEAT1 = 2'd2,
        M_ACC   = 2'd3
    } arbState_t;

    typedef enum logic {
        GRANT_F = 1'b0,
        GRANT_M = 1'b1
    } grant_t;

    // True when an access of accBytes starting at addr would run past the
    // end of memory. Comparing against (memBytes - accBytes) instead of
    // computing addr + accBytes keeps huge addresses from wrapping into range.
    function automatic logic outOfRange(input logic [63:0] addr,
                                        input int          memBytes,
                                        input int          accBytes);
        return addr > 64'(memBytes - accBytes);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single backing-memory port between the
// fetch stage (10-byte reads, two 8-byte beats) and the memory stage
// (8-byte reads/writes, one beat), with range checking on both.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   f_req/f_addr/f_flush       fetch request, byte address, result discard
//   f_valid/f_bytes/imem_error fetch response pulse, bytes, range error
//   f_wait                     fetch stall request (f_req & ~f_valid)
//   m_req/m_we/m_addr/m_wdata  data request, write enable, address, data
//   m_valid/m_rdata/dmem_error data response pulse, read data, range error
//   m_wait                     data stall request (m_req & ~m_valid)
//   mem_req/mem_we/mem_addr/mem_wdata  registered backing-memory request
//   mem_ready/mem_rdata        backing-memory completion and read data
module mem_port_arbiter
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        f_req,
    input  logic [63:0] f_addr,
    input  logic        f_flush,
    output logic        f_valid,
    output logic [79:0] f_bytes,
    output logic        imem_error,
    output logic        f_wait,

    input  logic        m_req,
    input  logic        m_we,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic        m_valid,
    output logic [63:0] m_rdata,
    output logic        dmem_error,
    output logic        m_wait,

    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata
);

    arbState_t state;
    grant_t    lastGrant;
    logic      flushSeen;

    logic      fPending;
    logic      mPending;
    logic      grantF;
    logic      grantM;

    assign f_wait = f_req & ~f_valid;
    assign m_wait = m_req & ~m_valid;

    // A requester whose response pulse is out this cycle is still holding
    // req for the transaction just finished, so it does not count as pending.
    always_comb begin
        fPending = f_req & ~f_valid;
        mPending = m_req & ~m_valid;
        grantF   = 1'b0;
        grantM   = 1'b0;
        if (fPending && mPending) begin
            if (lastGrant == GRANT_F) begin
                grantM = 1'b1;
            end else begin
                grantF = 1'b1;
            end
        end else begin
            grantF = fPending;
            grantM = mPending;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lastGrant  <= GRANT_F;
            flushSeen  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            f_valid    <= 1'b0;
            m_valid    <= 1'b0;
            f_bytes    <= '0;
            m_rdata    <= '0;
            imem_error <= 1'b0;
            dmem_error <= 1'b0;
        end else begin
            f_valid <= 1'b0;
            m_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grantF) begin
                        lastGrant <= GRANT_F;
                        if (outOfRange(f_addr, MEM_BYTES, INSTR_BYTES)) begin
                            // Error response without touching memory.
                            f_valid    <= ~f_flush;
                            imem_error <= 1'b1;
                            f_bytes    <= '0;
                        end else begin
                            state     <= F_BEAT0;
                            flushSeen <= f_flush;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= f_addr;
                            mem_wdata <= '0;
                        end
                    end else if (grantM) begin
                        lastGrant <= GRANT_M;
                        if (outOfRange(m_addr, MEM_BYTES, DATA_BYTES)) begin
                            m_valid    <= 1'b1;
                            dmem_error <= 1'b1;
                            m_rdata    <= '0;
                        end else begin
                            state     <= M_ACC;
                            mem_req   <= 1'b1;
                            mem_we    <= m_we;
                            mem_addr  <= m_addr;
                            mem_wdata <= m_wdata;
                        end
                    end
                end

                F_BEAT0: begin
                    if (f_flush) begin
                        flushSeen <= 1'b1;
                    end
                    // mem_req stays high across the beat boundary; only the
                    // address advances to the second 8-byte window.
                    if (mem_ready) begin
                        f_bytes[63:0] <= mem_rdata;
                        mem_addr      <= mem_addr + 64'd8;
                        state         <= F_BEAT1;
                    end
                end

                F_BEAT1: begin
                    if (mem_ready) begin
                        f_bytes[79:64] <= mem_rdata[15:0];
                        imem_error     <= 1'b0;
                        f_valid        <= ~(flushSeen | f_flush);
                        flushSeen      <= 1'b0;
                        mem_req        <= 1'b0;
                        state          <= IDLE;
                    end else if (f_flush) begin
                        flushSeen <= 1'b1;
                    end
                end

                M_ACC: begin
                    if (mem_ready) begin
                        m_rdata    <= mem_we ? 64'd0 : mem_rdata;
                        dmem_error <= 1'b0;
                        m_valid    <= 1'b1;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized scoreboard bench for
// mem_port_arbiter with a byte-array backing memory of configurable latency.
module tb_mem_port_arbiter;
    import y86_mem_pkg::*;

    localparam int MB = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, f_flush;
    logic [63:0] f_addr;
    logic        f_valid, imem_error, f_wait;
    logic [79:0] f_bytes;
    logic        m_req, m_we;
    logic [63:0] m_addr, m_wdata;
    logic        m_valid, dmem_error, m_wait;
    logic [63:0] m_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
        .f_valid(f_valid), .f_bytes(f_bytes), .imem_error(imem_error), .f_wait(f_wait),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_valid(m_valid), .m_rdata(m_rdata), .dmem_error(dmem_error), .m_wait(m_wait),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int assertCount = 0;
    int failCount   = 0;

    logic [80:0]  fExpQ[$];
    logic [64:0]  mExpQ[$];
    logic [63:0]  hsAddr[$];
    logic [7:0]   refMem [MB];

    function automatic logic [7:0] initByte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 5));
    endfunction

    // Backing memory: curLat wait cycles before each handshake.
    logic [7:0] mem [MB];
    logic       memLoaded = 1'b0;
    int         fixedLat  = 0;
    int         curLat    = 0;
    int         waitCount = 0;

    assign mem_ready = mem_req && (waitCount == curLat);

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < MB; i++) mem[i] <= initByte(i);
            memLoaded <= 1'b1;
        end else if (mem_req && mem_ready && mem_we) begin
            for (int i = 0; i < 8; i++)
                if (int'(mem_addr[11:0]) + i < MB)
                    mem[int'(mem_addr[11:0]) + i] <= mem_wdata[8*i +: 8];
        end
        if (!mem_req || mem_ready) begin
            waitCount <= 0;
            curLat    <= (fixedLat < 0) ? int'($urandom_range(0, 3)) : fixedLat;
        end else begin
            waitCount <= waitCount + 1;
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++)
            if (int'(mem_addr[11:0]) + i < MB)
                mem_rdata[8*i +: 8] = mem[int'(mem_addr[11:0]) + i];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: fetch returns 10 bytes or an error; data read returns
    // 8 bytes, write returns 0 and updates the reference memory.
    function automatic logic [80:0] expF(input logic [63:0] a);
        logic [79:0] b;
        b = '0;
        if (a > 64'(MB - 10)) return {1'b1, 80'h0};
        for (int i = 0; i < 10; i++) b[8*i +: 8] = refMem[int'(a[11:0]) + i];
        return {1'b0, b};
    endfunction

    function automatic void pushM(input logic we, input logic [63:0] a, input logic [63:0] wd);
        logic [63:0] d;
        d = '0;
        if (a > 64'(MB - 8)) begin
            mExpQ.push_back({1'b1, 64'h0});
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (we) refMem[int'(a[11:0]) + i] = wd[8*i +: 8];
                else    d[8*i +: 8] = refMem[int'(a[11:0]) + i];
            end
            mExpQ.push_back({1'b0, d});
        end
    endfunction

    // Monitor: pops and compares whenever a response pulse is presented.
    initial begin
        logic [80:0] fe;
        logic [64:0] me;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (f_valid) begin
                    if (fExpQ.size() == 0) chk("f_unexpected_valid", 128'(f_bytes), 128'(0));
                    else begin
                        fe = fExpQ.pop_front();
                        chk("f_resp", 128'({imem_error, f_bytes}), 128'(fe));
                    end
                end
                if (m_valid) begin
                    if (mExpQ.size() == 0) chk("m_unexpected_valid", 128'(m_rdata), 128'(0));
                    else begin
                        me = mExpQ.pop_front();
                        chk("m_resp", 128'({dmem_error, m_rdata}), 128'(me));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic waitResp(input bit isF, output int lat, output int weCyc, output int reqCyc);
        int start;
        bit got;
        start  = cyc;
        got    = 1'b0;
        weCyc  = 0;
        reqCyc = 0;
        hsAddr.delete();
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (mem_req) reqCyc++;
            if (mem_req && mem_we) weCyc++;
            if (mem_req && mem_ready) hsAddr.push_back(mem_addr);
            if (isF ? f_valid : m_valid) got = 1'b1;
            else if (k == 0) chk(isF ? "f_wait" : "m_wait", 128'(isF ? f_wait : m_wait), 128'(1));
        end
        lat = cyc - start;
        chk(isF ? "f_resp_timeout" : "m_resp_timeout", 128'(got), 128'(1));
    endtask

    task automatic dataOp(input logic we, input logic [63:0] a, input logic [63:0] wd,
                          input int memLat, output int lat, output int weCyc, output int reqCyc);
        @(negedge clk);
        fixedLat = memLat;
        m_req = 1'b1; m_we = we; m_addr = a; m_wdata = wd;
        pushM(we, a, wd);
        waitResp(1'b0, lat, weCyc, reqCyc);
        m_req = 1'b0; m_we = 1'b0;
    endtask

    task automatic fetchOp(input logic [63:0] a, input int memLat, output int lat, output int reqCyc);
        int weCyc;
        @(negedge clk);
        fixedLat = memLat;
        f_req = 1'b1; f_addr = a;
        fExpQ.push_back(expF(a));
        waitResp(1'b1, lat, weCyc, reqCyc);
        f_req = 1'b0;
    endtask

    task automatic chkQuiet(input string tag);
        chk({tag, "_memreq"}, 128'(mem_req), 128'(0));
        chk({tag, "_memctl"}, 128'({mem_we, mem_addr, mem_wdata}), 128'(0));
        chk({tag, "_valids"}, 128'({f_valid, m_valid, imem_error, dmem_error}), 128'(0));
        chk({tag, "_fbytes"}, 128'(f_bytes), 128'(0));
        chk({tag, "_mrdata"}, 128'(m_rdata), 128'(0));
    endtask

    initial begin
        int lat, weC, reqC, n, hs, fv;
        int order[4];
        logic [63:0] a, wd;
        logic we;
        for (int i = 0; i < MB; i++) refMem[i] = initByte(i);

        rst_n = 1'b0; f_req = 0; f_flush = 0; f_addr = 0;
        m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        repeat (3) @(negedge clk);
        chkQuiet("reset");
        rst_n = 1'b1;

        // Directed data writes/reads and fetch with zero-wait and waited memory.
        dataOp(1'b1, 64'h100, 64'h0000_0000_000A_F230, 0, lat, weC, reqC);
        chk("wr_zero_wait_latency", 128'(lat), 128'(2));
        dataOp(1'b1, 64'h108, 64'h0, 0, lat, weC, reqC);
        dataOp(1'b1, 64'h200, 64'hDEAD_BEEF, 2, lat, weC, reqC);
        chk("wr_2wait_latency", 128'(lat), 128'(4));
        chk("wr_2wait_we_cycles", 128'(weC), 128'(3));
        dataOp(1'b0, 64'h200, 64'h0, 1, lat, weC, reqC);
        chk("rd_1wait_latency", 128'(lat), 128'(3));
        chk("rd_readback", 128'(m_rdata), 128'(64'hDEAD_BEEF));

        fetchOp(64'h100, 0, lat, reqC);
        chk("fetch_latency", 128'(lat), 128'(3));
        chk("fetch_low_bytes", 128'(f_bytes[15:0]), 128'(16'hF230));
        chk("fetch_beats", 128'(hsAddr.size()), 128'(2));
        if (hsAddr.size() == 2) begin
            chk("fetch_beat0_addr", 128'(hsAddr[0]), 128'(64'h100));
            chk("fetch_beat1_addr", 128'(hsAddr[1]), 128'(64'h108));
        end

        // Range boundaries.
        dataOp(1'b0, 64'(MB - 7), 64'h0, 0, lat, weC, reqC);
        chk("m_oob_latency", 128'(lat), 128'(1));
        chk("m_oob_no_memreq", 128'(reqC), 128'(0));
        dataOp(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234, 0, lat, weC, reqC);
        chk("m_wrap_oob_latency", 128'(lat), 128'(1));
        dataOp(1'b0, 64'(MB - 8), 64'h0, 0, lat, weC, reqC);
        chk("m_last_inrange_latency", 128'(lat), 128'(2));
        fetchOp(64'(MB - 9), 0, lat, reqC);
        chk("f_oob_latency", 128'(lat), 128'(1));
        chk("f_oob_no_memreq", 128'(reqC), 128'(0));
        fetchOp(64'(MB - 10), 1, lat, reqC);
        chk("f_last_inrange_latency", 128'(lat), 128'(5));
        if (hsAddr.size() == 2) chk("f_last_beat1_addr", 128'(hsAddr[1]), 128'(64'(MB - 2)));

        // Reset while the first fetch beat is waiting on memory.
        @(negedge clk);
        fixedLat = 3; f_req = 1'b1; f_addr = 64'h100;
        @(negedge clk);
        chk("midrst_busy_before", 128'(mem_req), 128'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chkQuiet("midrst_edge1");
        @(negedge clk);
        chkQuiet("midrst_edge2");
        f_req = 1'b0; rst_n = 1'b1; fixedLat = 0;
        repeat (2) @(negedge clk);

        // Both requesters held from reset: grants alternate starting with data.
        rst_n = 1'b0;
        f_req = 1'b1; f_addr = 64'h100;
        m_req = 1'b1; m_we = 1'b0; m_addr = 64'h200;
        for (int i = 0; i < 2; i++) begin
            fExpQ.push_back(expF(64'h100));
            pushM(1'b0, 64'h200, 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (f_valid) begin order[n] = 0; n++; end
            else if (m_valid) begin order[n] = 1; n++; end
            if (n == 4) begin f_req = 1'b0; m_req = 1'b0; end
        end
        f_req = 1'b0; m_req = 1'b0;
        chk("both_held_responses", 128'(n), 128'(4));
        for (int i = 0; i < n; i++) chk("grant_order", 128'(order[i]), 128'((i % 2 == 0) ? 1 : 0));

        // Flush during the second fetch beat: memory port completes, no pulse.
        @(negedge clk);
        fixedLat = 1; f_req = 1'b1; f_addr = 64'h100;
        hs = 0; fv = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_req && mem_ready) hs++;
            if (f_valid) fv++;
            if (k == 3) f_flush = 1'b1;
            if (k == 4) begin f_flush = 1'b0; f_req = 1'b0; end
        end
        chk("flush_beats_completed", 128'(hs), 128'(2));
        chk("flush_no_valid", 128'(fv), 128'(0));
        fetchOp(64'h100, 0, lat, reqC);
        chk("after_flush_latency", 128'(lat), 128'(3));

        // Randomized concurrent traffic: fetch below 0x7F0, data at 0x800 and up.
        fixedLat = -1;
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    int gap, r;
                    bit got;
                    logic [63:0] fa;
                    gap = int'($urandom_range(0, 2));
                    if (gap > 0) begin f_req = 1'b0; repeat (gap) @(negedge clk); end
                    r = int'($urandom_range(0, 9));
                    if (r == 0)      fa = 64'(MB - 9) + 64'($urandom_range(0, 8));
                    else if (r == 1) fa = {32'h0000_0001, 32'($urandom)};
                    else             fa = 64'($urandom_range(0, 'h7F0));
                    f_req = 1'b1; f_addr = fa;
                    fExpQ.push_back(expF(fa));
                    got = 1'b0;
                    for (int k = 0; k < 200 && !got; k++) begin
                        @(negedge clk);
                        if (f_valid) got = 1'b1;
                    end
                    chk("rand_f_timeout", 128'(got), 128'(1));
                end
                f_req = 1'b0;
            end
            begin
                for (int t = 0; t < 40; t++) begin
                    int gap, r;
                    bit got;
                    logic [63:0] ma, mw;
                    logic mwe;
                    gap = int'($urandom_range(0, 2));
                    if (gap > 0) begin m_req = 1'b0; repeat (gap) @(negedge clk); end
                    r = int'($urandom_range(0, 9));
                    if (r == 0)      ma = 64'(MB - 7) + 64'($urandom_range(0, 6));
                    else if (r == 1) ma = {32'hFFFF_FFFF, 32'($urandom)};
                    else             ma = 64'($urandom_range('h800, MB - 8));
                    mwe = 1'($urandom_range(0, 1));
                    mw  = {32'($urandom), 32'($urandom)};
                    m_req = 1'b1; m_we = mwe; m_addr = ma; m_wdata = mw;
                    pushM(mwe, ma, mw);
                    got = 1'b0;
                    for (int k = 0; k < 200 && !got; k++) begin
                        @(negedge clk);
                        if (m_valid) got = 1'b1;
                    end
                    chk("rand_m_timeout", 128'(got), 128'(1));
                end
                m_req = 1'b0;
            end
        join

        repeat (6) @(negedge clk);
        chk("f_queue_drained", 128'(fExpQ.size()), 128'(0));
        chk("m_queue_drained", 128'(mExpQ.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
